// File: rtl/stopwatch_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// stopwatch_pkg: shared mode encoding and widths for the stopwatch control. Rev 1.0
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  localparam int DB_CYCLES_DEFAULT = 250000;
  localparam int BCD_W             = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// -----------------------------------------------------------------------------
// btn_debounce: 2-flop synchronizer, stable-level debouncer, press pulse. Rev 1.0
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int             CW       = $clog2(DB_CYCLES);
  // The flip happens on the edge where the count would reach DB_CYCLES-1.
  localparam logic [CW-1:0]  C_ACCEPT = CW'(DB_CYCLES - 2);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      if (r_sync2 != r_level) begin
        if (r_cnt == C_ACCEPT) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// stopwatch_ctrl: button-driven run/pause/lap/clear FSM with display freeze. Rev 1.0
// -----------------------------------------------------------------------------
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             BTN_START,
  input  logic             BTN_LAP,
  input  logic [BCD_W-1:0] COUNT_1,
  input  logic [BCD_W-1:0] COUNT_10,
  input  logic [BCD_W-1:0] COUNT_M,
  output logic             RUN,
  output logic             CLR,
  output logic             HOLD,
  output logic [BCD_W-1:0] DISP_1,
  output logic [BCD_W-1:0] DISP_10,
  output logic [BCD_W-1:0] DISP_M,
  output logic [1:0]       STATE
);

  logic             w_ps;
  logic             w_pl;
  state_t           r_state;
  state_t           w_state_next;
  logic             w_clr_next;
  logic             r_run;
  logic             r_hold;
  logic             r_clr;
  logic [BCD_W-1:0] r_disp_1;
  logic [BCD_W-1:0] r_disp_10;
  logic [BCD_W-1:0] r_disp_m;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk     (CLK),
    .rst     (RESET),
    .i_btn   (BTN_START),
    .o_press (w_ps)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .clk     (CLK),
    .rst     (RESET),
    .i_btn   (BTN_LAP),
    .o_press (w_pl)
  );

  // START is tested first everywhere so it wins over a coincident LAP.
  always_comb begin
    w_state_next = r_state;
    w_clr_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ps) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_ps)      w_state_next = ST_PAUSE;
        else if (w_pl) w_state_next = ST_LAP;
      end
      ST_LAP: begin
        if (w_ps)      w_state_next = ST_PAUSE;
        else if (w_pl) w_state_next = ST_RUN;
      end
      ST_PAUSE: begin
        if (w_ps) begin
          w_state_next = ST_RUN;
        end else if (w_pl) begin
          w_state_next = ST_IDLE;
          w_clr_next   = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Display follows the registered HOLD, so the load on the RUN->LAP edge is the snapshot.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_run     <= 1'b0;
      r_hold    <= 1'b0;
      r_clr     <= 1'b0;
      r_disp_1  <= '0;
      r_disp_10 <= '0;
      r_disp_m  <= '0;
    end else begin
      r_state <= w_state_next;
      r_run   <= (w_state_next == ST_RUN) || (w_state_next == ST_LAP);
      r_hold  <= (w_state_next == ST_LAP);
      r_clr   <= w_clr_next;
      if (!r_hold) begin
        r_disp_1  <= COUNT_1;
        r_disp_10 <= COUNT_10;
        r_disp_m  <= COUNT_M;
      end
    end
  end

  assign RUN     = r_run;
  assign CLR     = r_clr;
  assign HOLD    = r_hold;
  assign DISP_1  = r_disp_1;
  assign DISP_10 = r_disp_10;
  assign DISP_M  = r_disp_m;
  assign STATE   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl: directed vector bench for stopwatch_ctrl, DB_CYCLES=4. Rev 1.0
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  logic       CLK;
  logic       RESET;
  logic       BTN_START;
  logic       BTN_LAP;
  logic [3:0] COUNT_1;
  logic [3:0] COUNT_10;
  logic [3:0] COUNT_M;
  logic       RUN;
  logic       CLR;
  logic       HOLD;
  logic [3:0] DISP_1;
  logic [3:0] DISP_10;
  logic [3:0] DISP_M;
  logic [1:0] STATE;

  int checks   = 0;
  int failures = 0;
  int clr_total = 0;

  typedef struct {
    logic       bs;
    logic       bl;
    logic [3:0] c1;
    logic [3:0] c10;
    logic [3:0] cm;
    logic [1:0] st;
    logic       run;
    logic       hold;
    int         clr;
    logic [3:0] d1;
    logic [3:0] d10;
    logic [3:0] dm;
  } vec_t;

  vec_t vt[15];

  stopwatch_ctrl #(.DB_CYCLES(4)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BTN_START (BTN_START),
    .BTN_LAP   (BTN_LAP),
    .COUNT_1   (COUNT_1),
    .COUNT_10  (COUNT_10),
    .COUNT_M   (COUNT_M),
    .RUN       (RUN),
    .CLR       (CLR),
    .HOLD      (HOLD),
    .DISP_1    (DISP_1),
    .DISP_10   (DISP_10),
    .DISP_M    (DISP_M),
    .STATE     (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (CLR === 1'b1) clr_total++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  task automatic press(input logic s, input logic l);
    @(posedge CLK); #1;
    BTN_START = s;
    BTN_LAP   = l;
    repeat (10) @(posedge CLK);
    #1;
    BTN_START = 1'b0;
    BTN_LAP   = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
  endtask

  initial begin
    int clr0;
    BTN_START = 1'b0;
    BTN_LAP   = 1'b0;
    COUNT_1   = 4'd0;
    COUNT_10  = 4'd0;
    COUNT_M   = 4'd0;
    RESET     = 1'b0;

    //                bs    bl    c1 c10 cm  st    run   hold  clr d1 d10 dm
    vt[0]  = '{1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 0, 4'd0, 4'd0, 4'd0};
    vt[1]  = '{1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 0, 4'd1, 4'd0, 4'd0};
    vt[2]  = '{1'b1, 1'b0, 4'd3, 4'd2, 4'd1, 2'd1, 1'b1, 1'b0, 0, 4'd3, 4'd2, 4'd1};
    vt[3]  = '{1'b0, 1'b1, 4'd3, 4'd2, 4'd1, 2'd3, 1'b1, 1'b1, 0, 4'd3, 4'd2, 4'd1};
    vt[4]  = '{1'b0, 1'b0, 4'd7, 4'd2, 4'd1, 2'd3, 1'b1, 1'b1, 0, 4'd3, 4'd2, 4'd1};
    vt[5]  = '{1'b0, 1'b1, 4'd7, 4'd2, 4'd1, 2'd1, 1'b1, 1'b0, 0, 4'd7, 4'd2, 4'd1};
    vt[6]  = '{1'b1, 1'b0, 4'd8, 4'd2, 4'd1, 2'd2, 1'b0, 1'b0, 0, 4'd8, 4'd2, 4'd1};
    vt[7]  = '{1'b1, 1'b0, 4'd9, 4'd2, 4'd1, 2'd1, 1'b1, 1'b0, 0, 4'd9, 4'd2, 4'd1};
    vt[8]  = '{1'b0, 1'b1, 4'd0, 4'd3, 4'd1, 2'd3, 1'b1, 1'b1, 0, 4'd0, 4'd3, 4'd1};
    vt[9]  = '{1'b1, 1'b0, 4'd4, 4'd3, 4'd1, 2'd2, 1'b0, 1'b0, 0, 4'd4, 4'd3, 4'd1};
    vt[10] = '{1'b0, 1'b1, 4'd4, 4'd3, 4'd1, 2'd0, 1'b0, 1'b0, 1, 4'd4, 4'd3, 4'd1};
    vt[11] = '{1'b0, 1'b1, 4'd5, 4'd3, 4'd1, 2'd0, 1'b0, 1'b0, 0, 4'd5, 4'd3, 4'd1};
    vt[12] = '{1'b1, 1'b0, 4'd6, 4'd3, 4'd1, 2'd1, 1'b1, 1'b0, 0, 4'd6, 4'd3, 4'd1};
    vt[13] = '{1'b1, 1'b1, 4'd5, 4'd5, 4'd2, 2'd2, 1'b0, 1'b0, 0, 4'd5, 4'd5, 4'd2};
    vt[14] = '{1'b0, 1'b1, 4'd5, 4'd5, 4'd2, 2'd0, 1'b0, 1'b0, 1, 4'd5, 4'd5, 4'd2};

    // Reset state, held for 20 cycles after release.
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_state", 32'(STATE), 32'd0);
    chk("rst_run",   32'(RUN),   32'd0);
    chk("rst_hold",  32'(HOLD),  32'd0);
    chk("rst_clr",   32'(CLR),   32'd0);
    chk("rst_disp",  32'({DISP_M, DISP_10, DISP_1}), 32'd0);
    RESET = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      chk("idle_state", 32'(STATE), 32'd0);
      chk("idle_out",   32'({RUN, HOLD, CLR}), 32'd0);
    end
    chk("idle_disp", 32'({DISP_M, DISP_10, DISP_1}), 32'd0);

    // Bouncing START must not be accepted; the final rise lands exactly 7 edges later.
    for (int i = 0; i < 5; i++) begin
      BTN_START = 1'b1;
      repeat (2) @(posedge CLK);
      #1 BTN_START = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("bounce_state", 32'(STATE), 32'd0);
    end
    @(posedge CLK); #1;
    BTN_START = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(posedge CLK); #1;
      if (n < 7) chk("db_early_state", 32'(STATE), 32'd0);
    end
    chk("db_state", 32'(STATE), 32'd1);
    chk("db_run",   32'(RUN),   32'd1);
    BTN_START = 1'b0;
    repeat (12) @(posedge CLK);
    #1 do_reset();

    // Table-driven mode sequence.
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK); #1;
      COUNT_1  = vt[i].c1;
      COUNT_10 = vt[i].c10;
      COUNT_M  = vt[i].cm;
      clr0 = clr_total;
      if (vt[i].bs || vt[i].bl) press(vt[i].bs, vt[i].bl);
      else begin
        repeat (4) @(posedge CLK);
        #1;
      end
      chk($sformatf("v%0d_state", i), 32'(STATE), 32'(vt[i].st));
      chk($sformatf("v%0d_run", i),   32'(RUN),   32'(vt[i].run));
      chk($sformatf("v%0d_hold", i),  32'(HOLD),  32'(vt[i].hold));
      chk($sformatf("v%0d_clr", i),   32'(clr_total - clr0), 32'(vt[i].clr));
      chk($sformatf("v%0d_disp", i),  32'({DISP_M, DISP_10, DISP_1}),
          32'({vt[i].dm, vt[i].d10, vt[i].d1}));
    end

    // Asynchronous reset in LAP with a LAP debounce in progress.
    COUNT_1  = 4'd6;
    COUNT_10 = 4'd4;
    COUNT_M  = 4'd2;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("mid_pre_state", 32'(STATE), 32'd3);
    clr0 = clr_total;
    BTN_LAP = 1'b1;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("mid_state", 32'(STATE), 32'd0);
    chk("mid_hold",  32'(HOLD),  32'd0);
    chk("mid_run",   32'(RUN),   32'd0);
    chk("mid_clr",   32'(CLR),   32'd0);
    chk("mid_disp",  32'({DISP_M, DISP_10, DISP_1}), 32'd0);
    BTN_LAP = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    chk("post_state", 32'(STATE), 32'd0);
    chk("post_clr",   32'(clr_total - clr0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM for the seconds/minutes stopwatch counter. Takes two raw push-buttons (START/STOP and LAP/CLEAR), synchronizes and debounces them, and sequences the counter through idle, running, paused and lap-hold modes. Its outputs are the counter's run enable, a clear pulse, and a frozen or live copy of the three BCD digits for the display.

## Interface
Parameters:
- DB_CYCLES, 250000: consecutive stable CLK cycles required to accept a button level change (10 ms at 25 MHz); minimum 2.

Ports:
- CLK  in  1  system clock, 25 MHz; all flops on rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- BTN_START  in  1  raw START/STOP button, active-high, asynchronous to CLK.
- BTN_LAP  in  1  raw LAP/CLEAR button, active-high, asynchronous to CLK.
- COUNT_1  in  4  live seconds-ones digit from the counter.
- COUNT_10  in  4  live seconds-tens digit.
- COUNT_M  in  4  live minutes digit.
- RUN  out  1  counter enable; 1 = count, 0 = hold value.
- CLR  out  1  one-cycle registered clear pulse to the counter.
- HOLD  out  1  1 = display frozen at lap snapshot.
- DISP_1, DISP_10, DISP_M  out  4 each  digits to the display.
- STATE  out  2  current mode: 0 IDLE, 1 RUNNING, 2 PAUSED, 3 LAP.

## Operation
- Per button: 2-flop synchronizer, then debouncer. The debouncer compares the synchronized level with the accepted level.
  - Counter runs only while the two differ; any return to equality resets the counter to 0.
  - The accepted level flips when the counter reaches DB_CYCLES-1.
  - A 1-cycle press pulse is generated on the accepted level's 0->1 transition. Release produces no pulse.
- FSM transitions (P_S = START press pulse, P_L = LAP press pulse):
  - IDLE: P_S -> RUNNING. P_L ignored.
  - RUNNING: P_S -> PAUSED. P_L -> LAP, capturing COUNT_* into the snapshot registers.
  - LAP: P_L -> RUNNING (release the display). P_S -> PAUSED (release the display; counter stops).
  - PAUSED: P_S -> RUNNING. P_L -> IDLE with CLR asserted for exactly one cycle.
- Simultaneous P_S and P_L in the same cycle: P_S wins and P_L is discarded.
- Outputs, all registered:
  - RUN = 1 in RUNNING and LAP.
  - HOLD = 1 in LAP.
  - CLR = 1 only on the cycle after the PAUSED->IDLE transition edge.
- Display:
  - HOLD=0: DISP_* load COUNT_* every cycle.
  - HOLD=1: DISP_* keep the snapshot taken on the RUNNING->LAP edge.
- Reset values: STATE=IDLE, RUN=0, CLR=0, HOLD=0, DISP_*=0, synchronizers, accepted levels and debounce counters all 0.
- RESET mid-operation returns to IDLE immediately. No CLR pulse is issued, because the counter shares RESET.
- Debounce counter width: $clog2(DB_CYCLES). It never wraps; it saturates at the accept point and then resets.

## Timing
- Raw button change at edge k appears at the synchronizer output at edge k+2.
- If stable, the accepted level flips at edge k+2+DB_CYCLES-1 and the press pulse is high for the following cycle.
- STATE, RUN, HOLD and CLR update on the edge that samples the press pulse. Total raw-to-output latency = DB_CYCLES+3 cycles.
- Snapshot is captured on the same edge that sets HOLD=1.
- DISP_* lag COUNT_* by one cycle when live.
- CLR is a glitch-free flop output, safe to drive the counter's asynchronous reset.
- Pulses cannot repeat faster than 2·DB_CYCLES cycles (press plus release). No FSM guard against back-to-back pulses is required.

## Structure
- Package stopwatch_pkg holds:
  - state encoding constants ST_IDLE=0, ST_RUN=1, ST_PAUSE=2, ST_LAP=3;
  - default DB_CYCLES;
  - BCD digit width 4.
- Sub-module btn_debounce (synchronizer, debouncer and press-pulse generator), parameterized by DB_CYCLES, instantiated twice.
- Top level holds the FSM and the snapshot/display registers.

## Test plan
Bench uses DB_CYCLES=4.
- Reset: assert RESET with buttons idle -> STATE=0, RUN=0, HOLD=0, CLR=0, DISP_*=0; all remain so 20 cycles after release.
- Debounce: toggle BTN_START every 2 cycles for 20 cycles, then hold high -> no press pulse during toggling; STATE 0->1 and RUN=1 exactly 7 cycles after the final rise.
- Lap freeze: in RUNNING with COUNT_*=3/2/1, press LAP, then change COUNT_* to 7/2/1 -> HOLD=1, STATE=3, DISP_*=3/2/1 held. Press LAP again -> HOLD=0, DISP_*=7/2/1 one cycle later.
- Pause/clear: RUNNING, press START -> STATE=2, RUN=0. Press LAP -> STATE=0 and CLR high for exactly 1 cycle. A further LAP press in IDLE gives no CLR.
- Simultaneous: in RUNNING, make both accepted press pulses fire in the same cycle -> STATE=2, HOLD stays 0, no snapshot taken.
- Reset mid-op: assert RESET while in LAP with a debounce count in progress -> STATE=0, HOLD=0, DISP_*=0, CLR=0. A half-debounced press does not register after release.
